kpn_arith_node: RTL and testbench
=================================

# kpn_arith_node

Parametrised Kahn-process-network arithmetic node: buffers NUM_CH input token streams in per-channel FIFOs, fires when every channel holds a token and the output slot can accept a result, and produces one WIDTH-bit result per firing under a selectable operation mode. It replaces the fixed two-FIFO-plus-adder chain in the display pipeline; its output feeds the BCD converter and display stage, or another node's input channel.

## Interface
- WIDTH, 16, token width in bits (8..32)
- DEPTH, 8, per-channel FIFO depth; power of two, 2..64
- NUM_CH, 2, number of input channels (2..4)
- clk  in  1  node clock (the divided KPN clock in the display pipeline)
- reset  in  1  asynchronous, active-high; clears all state
- wr  in  NUM_CH  per-channel write strobe; bit i writes channel i
- entry  in  NUM_CH*WIDTH  input tokens; channel i occupies bits [i*WIDTH +: WIDTH]
- mode  in  2  operation select, sampled at firing
- rd  in  1  consumer pops output_1 when out_valid=1
- output_1  out  WIDTH  result token
- out_valid  out  1  output_1 holds an unread result
- full  out  NUM_CH  per-channel FIFO full
- empty  out  NUM_CH  per-channel FIFO empty
- overflow  out  1  sticky; result exceeded unsigned WIDTH range since reset

## Operation
- Per-channel FIFO: circular buffer, read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Write: accepted when wr[i]=1 and (full[i]=0, or channel i is popped in the same cycle). Writes to a full, unpopped channel are dropped; state unchanged.
- No fall-through: a token written into an empty FIFO becomes eligible at the next edge.
- Firing rule: fire = all empty[i]=0 AND (out_valid=0 OR rd=1). Firing pops the head of every channel in that cycle.
- FSM: IDLE (out_valid=0) -> FULL on fire; FULL -> IDLE on rd with no fire; FULL -> FULL on rd with fire (back-to-back); FULL holds while rd=0. rd in IDLE is ignored.
- Modes (all unsigned, result truncated to WIDTH bits, modulo 2^WIDTH):
  - 00 SUM: sum of all channel heads.
  - 01 DIFF: head0 minus sum of heads 1..NUM_CH-1.
  - 10 ACC: acc <= acc + sum of heads; output_1 = new acc. acc updates only on ACC firings.
  - 11 MAX: largest head; never overflows.
- Overflow: SUM/ACC set overflow when the full-precision sum (WIDTH+2 bits) exceeds 2^WIDTH-1; DIFF sets it when the result is negative. Sticky until reset.
- Reset (async, any time, including mid-firing): FIFOs empty, pointers 0, acc=0, output_1=0, out_valid=0, overflow=0, full=0, empty=all ones; in-flight tokens are discarded.

## Timing
- All outputs registered; full/empty reflect counts after the last edge.
- Latency: token written at edge t; eligible at t+1; if all channels are eligible, fire at edge t+1 and output_1/out_valid update at that edge, visible in cycle t+1..t+2.
- Throughput: one firing per cycle while inputs are available and rd=1 each cycle.
- Simultaneous write + pop on one channel: count unchanged; write allowed even when full.
- mode changes take effect at the next firing; an already-registered result is unaffected.

## Test plan
- Reset then NUM_CH=2, SUM: write 5 and 7 together, hold rd=0 -> out_valid=1, output_1=12 one edge after eligibility; result holds until rd; empty=2'b11 after firing.
- DIFF: channels 3 and 10 -> output_1=16'hFFF9, overflow=1 and stays 1 through later valid firings; reset clears it.
- ACC: three firings of (1,2), (3,4), (5,6) with rd=1 -> outputs 3, 10, 21; switch to SUM then back to ACC with (1,1) -> 23.
- Full/drop: write 9 tokens to channel 0 only with DEPTH=8 -> full[0]=1 after 8, 9th dropped; feed channel 1 and read -> channel 0 yields exactly the first 8 tokens in order, pointers wrap correctly.
- Back-to-back: both FIFOs preloaded with 4 tokens, rd=1 every cycle -> 4 results on 4 consecutive cycles, then out_valid=0; with rd=0 after the first result, no further pops occur.
- Async reset asserted mid-stream with out_valid=1 and FIFOs half full -> all outputs return to reset values immediately, without waiting for a clock edge; the first post-reset firing uses only new tokens.

Source files
------------

// File: rtl/kpn_arith_node.sv
// kpn_arith_node: NUM_CH input FIFOs feeding one arithmetic firing stage.
// The node fires when every channel holds a token and the output slot is free
// or being read in the same cycle. Each firing pops one head per channel and
// registers one WIDTH-bit result.
module kpn_arith_node #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       wr,
  input  logic [NUM_CH*WIDTH-1:0] entry,
  input  logic [1:0]              mode,
  input  logic                    rd,
  output logic [WIDTH-1:0]        output_1,
  output logic                    out_valid,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Wide enough for acc plus four full-scale heads without wrapping.
  localparam int unsigned SW = WIDTH + 3;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  localparam logic [1:0] ModeSum  = 2'b00;
  localparam logic [1:0] ModeDiff = 2'b01;
  localparam logic [1:0] ModeAcc  = 2'b10;
  localparam logic [1:0] ModeMax  = 2'b11;

  typedef enum logic {StIdle, StFull} state_e;

  logic [WIDTH-1:0] mem_q  [NUM_CH][DEPTH];
  logic [AW-1:0]    rptr_q [NUM_CH];
  logic [AW-1:0]    wptr_q [NUM_CH];
  logic [CW-1:0]    cnt_q  [NUM_CH];
  logic [WIDTH-1:0] head   [NUM_CH];

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;

  logic              fire;
  logic [NUM_CH-1:0] wr_acc;
  logic [SW-1:0]     sum_all;
  logic [SW-1:0]     sum_rest;
  logic [SW-1:0]     acc_sum;
  logic [WIDTH-1:0]  max_v;
  logic [WIDTH-1:0]  diff;
  logic [WIDTH-1:0]  res_d;
  logic              ovf_d;

  // FIFO status flags and head tokens, derived from registered counts/pointers.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      full[i]  = (cnt_q[i] == FullCnt);
      empty[i] = (cnt_q[i] == '0);
      head[i]  = mem_q[i][rptr_q[i]];
    end
  end

  assign out_valid = (state_q == StFull);
  assign fire      = (~|empty) && (!out_valid || rd);
  // A full channel still accepts a write when the same cycle pops it.
  assign wr_acc    = wr & (~full | {NUM_CH{fire}});

  // Firing datapath: full-precision sums, max and mode-selected result.
  always_comb begin
    sum_all  = '0;
    sum_rest = '0;
    max_v    = head[0];
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum_all = sum_all + SW'(head[i]);
      if (i > 0) sum_rest = sum_rest + SW'(head[i]);
      if (head[i] > max_v) max_v = head[i];
    end
    acc_sum = SW'(acc_q) + sum_all;
    diff    = head[0] - sum_rest[WIDTH-1:0];
    res_d   = sum_all[WIDTH-1:0];
    ovf_d   = 1'b0;
    case (mode)
      ModeSum: begin
        res_d = sum_all[WIDTH-1:0];
        ovf_d = |sum_all[SW-1:WIDTH];
      end
      ModeDiff: begin
        res_d = diff;
        ovf_d = (sum_rest > SW'(head[0]));
      end
      ModeAcc: begin
        res_d = acc_sum[WIDTH-1:0];
        ovf_d = |acc_sum[SW-1:WIDTH];
      end
      ModeMax: begin
        res_d = max_v;
        ovf_d = 1'b0;
      end
      default: begin
        res_d = sum_all[WIDTH-1:0];
        ovf_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the counts gate every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_acc[i]) mem_q[i][wptr_q[i]] <= entry[i*WIDTH +: WIDTH];
    end
  end

  // FIFO pointers and counts; every channel pops together on a firing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_acc[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (fire)      rptr_q[i] <= rptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(wr_acc[i]) - CW'(fire);
      end
    end
  end

  // Output slot FSM with registered result, accumulator and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (fire) begin
        result_q <= res_d;
        if (mode == ModeAcc) acc_q <= acc_sum[WIDTH-1:0];
        if (ovf_d) ovf_q <= 1'b1;
      end
      case (state_q)
        StIdle:  if (fire) state_q <= StFull;
        StFull:  if (rd && !fire) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign output_1 = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_kpn_arith_node.sv
// Directed bench for kpn_arith_node (WIDTH=16, DEPTH=8, NUM_CH=2) with a
// queue of expected results consumed whenever the bench reads output_1.
module tb_kpn_arith_node;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NUM_CH = 2;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       wr;
  logic [NUM_CH*WIDTH-1:0] entry;
  logic [1:0]              mode;
  logic                    rd;
  logic [WIDTH-1:0]        output_1;
  logic                    out_valid;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       empty;
  logic                    overflow;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  kpn_arith_node #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NUM_CH(NUM_CH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .entry    (entry),
    .mode     (mode),
    .rd       (rd),
    .output_1 (output_1),
    .out_valid(out_valid),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] w, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b);
    wr    = w;
    entry = {b, a};
    cycle();
    wr    = '0;
  endtask

  // Read the registered result, comparing it with the oldest expectation.
  task automatic take(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, output_1);
    end else begin
      chk(tag, 32'(output_1), 32'(exp_q.pop_front()));
    end
    rd = 1'b1;
    cycle();
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr    = '0;
    entry = '0;
    mode  = 2'b00;
    rd    = 1'b0;
    cycle();
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_out", 32'(output_1), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    cycle();

    // SUM 5 + 7, result held while rd=0.
    put(2'b11, 16'd5, 16'd7);
    exp_q.push_back(16'd12);
    chk("sum_pre_valid", 32'(out_valid), 32'd0);
    chk("sum_pre_empty", 32'(empty), 32'h0);
    cycle();
    chk("sum_valid", 32'(out_valid), 32'd1);
    chk("sum_out", 32'(output_1), 32'(exp_q[0]));
    chk("sum_empty", 32'(empty), 32'h3);
    cycle();
    chk("sum_hold", 32'(output_1), 32'(exp_q[0]));
    take("sum_take");
    chk("sum_idle", 32'(out_valid), 32'd0);

    // DIFF 3 - 10 wraps and sets sticky overflow.
    mode = 2'b01;
    put(2'b11, 16'd3, 16'd10);
    exp_q.push_back(16'hFFF9);
    cycle();
    chk("diff_ovf", 32'(overflow), 32'd1);
    take("diff_out");
    mode = 2'b00;
    put(2'b11, 16'd5, 16'd5);
    exp_q.push_back(16'd10);
    cycle();
    take("sticky_out");
    chk("sticky_ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    #1;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // ACC across three firings, interrupted by a SUM firing.
    mode = 2'b10;
    put(2'b11, 16'd1, 16'd2);
    exp_q.push_back(16'd3);
    cycle();
    take("acc1");
    put(2'b11, 16'd3, 16'd4);
    exp_q.push_back(16'd10);
    cycle();
    take("acc2");
    put(2'b11, 16'd5, 16'd6);
    exp_q.push_back(16'd21);
    cycle();
    take("acc3");
    mode = 2'b00;
    put(2'b11, 16'd2, 16'd2);
    exp_q.push_back(16'd4);
    cycle();
    take("acc_sum_between");
    mode = 2'b10;
    put(2'b11, 16'd1, 16'd1);
    exp_q.push_back(16'd23);
    cycle();
    take("acc4");
    chk("acc_ovf", 32'(overflow), 32'd0);

    // Fill channel 0 past capacity; the 9th token must be dropped.
    mode = 2'b00;
    for (int k = 0; k < 8; k++) put(2'b01, 16'(100 + k), 16'd0);
    chk("fill_full", 32'(full), 32'h1);
    put(2'b01, 16'd999, 16'd0);
    chk("drop_full", 32'(full), 32'h1);
    chk("drop_empty", 32'(empty), 32'h2);
    for (int k = 0; k < 8; k++) begin
      put(2'b10, 16'd0, 16'd1000);
      exp_q.push_back(16'(1100 + k));
      cycle();
      take("fifo_order");
    end
    chk("drained_empty", 32'(empty), 32'h3);
    put(2'b11, 16'd1, 16'd2);
    exp_q.push_back(16'd3);
    cycle();
    take("wrap_out");

    // Back-to-back: ch0 preloaded, then ch1; stall with rd=0, then stream.
    for (int k = 1; k <= 4; k++) put(2'b01, 16'(k), 16'd0);
    for (int k = 1; k <= 4; k++) begin
      put(2'b10, 16'd0, 16'(20 * k));
      exp_q.push_back(16'(21 * k));
    end
    cycle();
    cycle();
    chk("b2b_stall_valid", 32'(out_valid), 32'd1);
    chk("b2b_stall_out", 32'(output_1), 32'd21);
    chk("b2b_stall_empty", 32'(empty), 32'h0);
    rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_out", 32'(output_1), 32'(exp_q.pop_front()));
      cycle();
    end
    chk("b2b_done", 32'(out_valid), 32'd0);
    chk("b2b_empty", 32'(empty), 32'h3);
    rd = 1'b0;

    // MAX and SUM overflow.
    mode = 2'b11;
    put(2'b11, 16'd30, 16'd200);
    exp_q.push_back(16'd200);
    cycle();
    take("max1");
    put(2'b11, 16'd500, 16'd7);
    exp_q.push_back(16'd500);
    cycle();
    take("max2");
    chk("max_ovf", 32'(overflow), 32'd0);
    mode = 2'b00;
    put(2'b11, 16'hFFFF, 16'd2);
    exp_q.push_back(16'd1);
    cycle();
    take("sum_wrap");
    chk("sum_ovf", 32'(overflow), 32'd1);

    // Asynchronous reset mid-stream with a pending result and queued tokens.
    for (int k = 1; k <= 4; k++) put(2'b11, 16'(k), 16'(k));
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_empty", 32'(empty), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_out", 32'(output_1), 32'd0);
    chk("async_empty", 32'(empty), 32'h3);
    chk("async_full", 32'(full), 32'h0);
    chk("async_ovf", 32'(overflow), 32'd0);
    exp_q.delete();
    cycle();
    reset = 1'b0;
    cycle();
    put(2'b11, 16'd50, 16'd60);
    exp_q.push_back(16'd110);
    cycle();
    take("post_reset");
    chk("post_reset_idle", 32'(out_valid), 32'd0);
    chk("post_reset_empty", 32'(empty), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
